// File: rtl/benes_stage_router_if.sv
// Request/response bundle for benes_stage_router: permutation in, switch selects and sub-permutations out.
// XBOT supplies the default port count when not set externally.
`ifndef XBOT
`define XBOT 8
`endif

interface benes_stage_router_if #(
    parameter int XREQ_SIZE = `XBOT
);
    localparam int IDX_W = $clog2(XREQ_SIZE);

    logic                                   req_valid;
    logic                                   req_ready;
    logic [XREQ_SIZE-1:0][IDX_W-1:0]        req_perm;
    logic                                   rsp_valid;
    logic                                   rsp_ready;
    logic [XREQ_SIZE/2-1:0]                 rsp_left_sel;
    logic [XREQ_SIZE/2-1:0]                 rsp_right_sel;
    logic [XREQ_SIZE/2-1:0][IDX_W-2:0]      rsp_upper_perm;
    logic [XREQ_SIZE/2-1:0][IDX_W-2:0]      rsp_lower_perm;
    logic                                   rsp_err;

    modport master (
        output req_valid, req_perm, rsp_ready,
        input  req_ready, rsp_valid, rsp_left_sel, rsp_right_sel,
               rsp_upper_perm, rsp_lower_perm, rsp_err
    );

    modport slave (
        input  req_valid, req_perm, rsp_ready,
        output req_ready, rsp_valid, rsp_left_sel, rsp_right_sel,
               rsp_upper_perm, rsp_lower_perm, rsp_err
    );
endinterface

// File: rtl/benes_stage_router.sv
// Looping-algorithm router for one outer Benes stage pair: one left switch decided per WALK cycle.
// Optional duplicate-destination check is compiled in with ROUTE_CHECK_EN.
`ifndef XBOT
`define XBOT 8
`endif

module benes_stage_router #(
    parameter int XREQ_SIZE = `XBOT
) (
    input  logic                      clock,
    input  logic                      reset,
    benes_stage_router_if.slave       bus
);
    localparam int IDX_W = $clog2(XREQ_SIZE);
    localparam int HALF  = XREQ_SIZE / 2;
    localparam int SW_W  = IDX_W - 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WALK, S_DONE} state_t;

    state_t                          r_state, w_state_nxt;
    logic [XREQ_SIZE-1:0][IDX_W-1:0] r_perm;
    logic [XREQ_SIZE-1:0][IDX_W-1:0] r_inv;
    logic [HALF-1:0]                 r_visited;
    logic [SW_W-1:0]                 r_cur_s;
    logic [IDX_W-1:0]                r_cur_a;
    logic [SW_W-1:0]                 r_step;
    logic [HALF-1:0]                 r_sel_l, r_sel_r;
    logic [HALF-1:0][SW_W-1:0]       r_upper, r_lower;

    logic [IDX_W-1:0]                w_o, w_o_partner, w_b;
    logic [SW_W-1:0]                 w_s_chain, w_s_free;
    logic [HALF-1:0]                 w_vis_nxt;
    logic                            w_last;
    logic                            w_dup;

    always_comb begin
        w_o         = r_perm[r_cur_a];
        w_o_partner = r_perm[{r_cur_a[IDX_W-1:1], ~r_cur_a[0]}];
        w_b         = r_inv[{w_o[IDX_W-1:1], ~w_o[0]}];
        w_s_chain   = w_b[IDX_W-1:1];
        w_vis_nxt   = r_visited | (HALF'(1) << r_cur_s);
        w_last      = (r_step == SW_W'(HALF - 1));
        // Downward scan so the lowest unvisited switch wins.
        w_s_free    = '0;
        for (int unsigned i = HALF; i > 0; i--) begin
            if (!w_vis_nxt[SW_W'(i - 1)]) w_s_free = SW_W'(i - 1);
        end
    end

`ifdef ROUTE_CHECK_EN
    logic r_err;

    always_comb begin
        w_dup = 1'b0;
        for (int unsigned i = 0; i < XREQ_SIZE; i++) begin
            for (int unsigned j = i + 1; j < XREQ_SIZE; j++) begin
                if (r_perm[IDX_W'(i)] == r_perm[IDX_W'(j)]) w_dup = 1'b1;
            end
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.req_valid) w_state_nxt = S_LOAD;
            S_LOAD: w_state_nxt = w_dup ? S_DONE : S_WALK;
            S_WALK: if (w_last) w_state_nxt = S_DONE;
            S_DONE: if (bus.rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready      = (r_state == S_IDLE) && !reset;
        bus.rsp_valid      = (r_state == S_DONE);
        bus.rsp_left_sel   = r_sel_l;
        bus.rsp_right_sel  = r_sel_r;
        bus.rsp_upper_perm = r_upper;
        bus.rsp_lower_perm = r_lower;
`ifdef ROUTE_CHECK_EN
        bus.rsp_err        = r_err;
`else
        bus.rsp_err        = 1'b0;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_perm    <= '0;
            r_inv     <= '0;
            r_visited <= '0;
            r_cur_s   <= '0;
            r_cur_a   <= '0;
            r_step    <= '0;
            r_sel_l   <= '0;
            r_sel_r   <= '0;
            r_upper   <= '0;
            r_lower   <= '0;
`ifdef ROUTE_CHECK_EN
            r_err     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (bus.req_valid) r_perm <= bus.req_perm;
                S_LOAD: begin
                    for (int unsigned i = 0; i < XREQ_SIZE; i++) begin
                        r_inv[r_perm[IDX_W'(i)]] <= IDX_W'(i);
                    end
                    r_visited <= '0;
                    r_cur_s   <= '0;
                    r_cur_a   <= '0;
                    r_step    <= '0;
                    r_sel_l   <= '0;
                    r_sel_r   <= '0;
                    r_upper   <= '0;
                    r_lower   <= '0;
`ifdef ROUTE_CHECK_EN
                    r_err     <= w_dup;
`endif
                end
                S_WALK: begin
                    r_sel_l[r_cur_s]         <= r_cur_a[0];
                    r_sel_r[w_o[IDX_W-1:1]]  <= w_o[0];
                    r_upper[r_cur_s]         <= w_o[IDX_W-1:1];
                    r_lower[r_cur_s]         <= w_o_partner[IDX_W-1:1];
                    r_visited                <= w_vis_nxt;
                    r_step                   <= r_step + 1'b1;
                    // Chain closure falls straight through to the next fresh switch.
                    if (!w_vis_nxt[w_s_chain]) begin
                        r_cur_s <= w_s_chain;
                        r_cur_a <= {w_b[IDX_W-1:1], ~w_b[0]};
                    end else begin
                        r_cur_s <= w_s_free;
                        r_cur_a <= {w_s_free, 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
